// File: rtl/lsu_pkg.sv
// ============================================================================
// Module : lsu_pkg
// Brief  : Shared funct3 codes, FSM encoding and lane helpers for dmem_lsu.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package lsu_pkg;

    localparam logic [2:0] FUNC_LB  = 3'b000;
    localparam logic [2:0] FUNC_LH  = 3'b001;
    localparam logic [2:0] FUNC_LW  = 3'b010;
    localparam logic [2:0] FUNC_LBU = 3'b100;
    localparam logic [2:0] FUNC_LHU = 3'b101;
    localparam logic [2:0] FUNC_SB  = 3'b000;
    localparam logic [2:0] FUNC_SH  = 3'b001;
    localparam logic [2:0] FUNC_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } lsu_state_e;

    function automatic logic illegal_f3(input logic we, input logic [2:0] f3);
        if (we) begin
            return !(f3 == FUNC_SB || f3 == FUNC_SH || f3 == FUNC_SW);
        end
        return !(f3 == FUNC_LB || f3 == FUNC_LH || f3 == FUNC_LW ||
                 f3 == FUNC_LBU || f3 == FUNC_LHU);
    endfunction

    // Halfword codes share low bits 01, word codes 10, for loads and stores alike.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] addr);
        case (f3[1:0])
            2'b01:   return addr[0];
            2'b10:   return (addr != 2'b00);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] lane);
        case (f3)
            FUNC_SB: return 4'b0001 << lane;
            FUNC_SH: return lane[1] ? 4'b1100 : 4'b0011;
            FUNC_SW: return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [2:0]  f3,
                                                input logic [1:0]  lane);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            FUNC_LB:  return {{24{b[7]}}, b};
            FUNC_LBU: return {24'h0, b};
            FUNC_LH:  return {{16{h[15]}}, h};
            FUNC_LHU: return {16'h0, h};
            FUNC_LW:  return word;
            default:  return 32'h0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_ram.sv
// ============================================================================
// Module : dmem_ram
// Brief  : Single-port synchronous word RAM with byte write enables and a
//          registered read port. Contents are never reset.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dmem_ram #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic                  re_i,
    input  logic [DATA_W/8-1:0]   be_i,
    input  logic [ADDR_W-1:0]     addr_i,
    input  logic [DATA_W-1:0]     wdata_i,
    output logic [DATA_W-1:0]     rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int i = 0; i < DATA_W/8; i++) begin
                if (be_i[i]) begin
                    mem_q[addr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
                end
            end
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/dmem_lsu.sv
// ============================================================================
// Module : dmem_lsu
// Brief  : Data-memory load/store responder: valid/ready request, byte-lane
//          stores, extended loads, held response. Optional LSU_BACK2BACK_EN
//          lets RESP accept the next request for 2-cycle throughput.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dmem_lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [2:0]        funct3_i,
    input  logic [31:0]       addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              busy_o
);

    lsu_state_e          state_q, state_d;
    logic                we_q, we_d;
    logic [2:0]          f3_q, f3_d;
    logic [ADDR_W+1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                err_q, err_d;

    logic                accept;
    logic                err_now;
    logic                ram_we, ram_re;
    logic [3:0]          ram_be;
    logic [DATA_W-1:0]   ram_wdata, ram_rdata;

    logic                unused_addr;
    assign unused_addr = ^addr_i[31:ADDR_W+2];

    always_comb begin
        err_now = illegal_f3(we_q, f3_q) | misaligned(f3_q, addr_q[1:0]);
        // RAM is only touched on the edge leaving ACCESS; an async reset there
        // drops the state to IDLE first, so the store never commits.
        ram_we  = (state_q == ACCESS) && we_q && !err_now;
        ram_re  = (state_q == ACCESS) && !we_q && !err_now;
        ram_be  = store_be(f3_q, addr_q[1:0]);
        case (f3_q)
            FUNC_SB: ram_wdata = {4{wdata_q[7:0]}};
            FUNC_SH: ram_wdata = {2{wdata_q[15:0]}};
            default: ram_wdata = wdata_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        busy_o      = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                state_d = RESP;
            end
            RESP: begin
                rsp_valid_o = 1'b1;
`ifdef LSU_BACK2BACK_EN
                req_ready_o = rsp_ready_i;
`else
                req_ready_o = 1'b0;
`endif
                if (rsp_ready_i) begin
                    state_d = (req_valid_i && req_ready_o) ? ACCESS : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        accept  = req_valid_i && req_ready_o;
        we_d    = accept ? req_we_i : we_q;
        f3_d    = accept ? funct3_i : f3_q;
        addr_d  = accept ? addr_i[ADDR_W+1:0] : addr_q;
        wdata_d = accept ? wdata_i : wdata_q;
        err_d   = (state_q == ACCESS) ? err_now : err_q;
    end

    // Response fields derive from registers that cannot change while in RESP.
    assign rsp_rdata_o = (state_q == RESP && !we_q && !err_q)
                       ? load_extend(ram_rdata, f3_q, addr_q[1:0]) : '0;
    assign rsp_err_o   = (state_q == RESP) && err_q;

    dmem_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .re_i    (ram_re),
        .be_i    (ram_be),
        .addr_i  (addr_q[ADDR_W+1:2]),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

endmodule

`default_nettype wire

// File: tb/tb_dmem_lsu.sv
// ============================================================================
// Module : tb_dmem_lsu
// Brief  : Directed self-checking bench for dmem_lsu (LSU_BACK2BACK_EN aware).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dmem_lsu;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    int n_cmp;
    int n_mis;

    dmem_lsu #(.ADDR_W(5), .DATA_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_we_i    (req_we),
        .funct3_i    (funct3),
        .addr_i      (addr),
        .wdata_i     (wdata),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_rdata_o (rsp_rdata),
        .rsp_err_o   (rsp_err),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runs one transaction with rsp_ready high; lat counts edges from the
    // accept edge (1) to the edge after which rsp_valid is seen.
    task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] rd,
                       output logic er, output int lat);
        int n;
        req_valid = 1'b1; req_we = we; funct3 = f3; addr = a; wdata = wd;
        rsp_ready = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (!req_ready) begin
            req_valid = 1'b0; rd = 32'hxxxxxxxx; er = 1'bx; lat = 99;
            return;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        rd = rsp_rdata;
        er = rsp_err;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_mis++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_mis++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        n_cmp++; if (rsp_rdata !== 32'h0) begin n_mis++; $display("FAIL reset_rsp_rdata: got %h want 0", rsp_rdata); end
        n_cmp++; if (rsp_err !== 1'b0) begin n_mis++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
        n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (busy !== 1'b0 || req_ready !== 1'b1) begin n_mis++; $display("FAIL idle_after_reset: got busy=%b ready=%b want 0/1", busy, req_ready); end
    endtask

    task automatic test_store_load;
        logic [31:0] rd; logic er; int lat;
        txn(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, er, lat);
        n_cmp++; if (lat !== 2) begin n_mis++; $display("FAIL sw_latency: got %0d want 2", lat); end
        n_cmp++; if (er !== 1'b0 || rd !== 32'h0) begin n_mis++; $display("FAIL sw_resp: got err=%b rdata=%h want 0/0", er, rd); end
        txn(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat);
        n_cmp++; if (lat !== 2) begin n_mis++; $display("FAIL lw_latency: got %0d want 2", lat); end
        n_cmp++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin n_mis++; $display("FAIL lw_0x10: got %h err=%b want deadbeef err=0", rd, er); end
        n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL busy_after_retire: got %b want 0", busy); end
    endtask

    task automatic test_extend;
        logic [31:0] rd; logic er; int lat;
        txn(1'b0, 3'b000, 32'h13, 32'h0, rd, er, lat);
        n_cmp++; if (rd !== 32'hFFFFFFDE) begin n_mis++; $display("FAIL lb_0x13: got %h want ffffffde", rd); end
        txn(1'b0, 3'b100, 32'h13, 32'h0, rd, er, lat);
        n_cmp++; if (rd !== 32'h000000DE) begin n_mis++; $display("FAIL lbu_0x13: got %h want 000000de", rd); end
        txn(1'b0, 3'b001, 32'h12, 32'h0, rd, er, lat);
        n_cmp++; if (rd !== 32'hFFFFDEAD) begin n_mis++; $display("FAIL lh_0x12: got %h want ffffdead", rd); end
        txn(1'b0, 3'b101, 32'h10, 32'h0, rd, er, lat);
        n_cmp++; if (rd !== 32'h0000BEEF) begin n_mis++; $display("FAIL lhu_0x10: got %h want 0000beef", rd); end
        txn(1'b0, 3'b000, 32'h10, 32'h0, rd, er, lat);
        n_cmp++; if (rd !== 32'hFFFFFFEF) begin n_mis++; $display("FAIL lb_0x10: got %h want ffffffef", rd); end
        txn(1'b0, 3'b100, 32'h11, 32'h0, rd, er, lat);
        n_cmp++; if (rd !== 32'h000000BE) begin n_mis++; $display("FAIL lbu_0x11: got %h want 000000be", rd); end
    endtask

    task automatic test_errors;
        logic [31:0] rd; logic er; int lat;
        txn(1'b0, 3'b010, 32'h12, 32'h0, rd, er, lat);
        n_cmp++; if (er !== 1'b1 || rd !== 32'h0) begin n_mis++; $display("FAIL lw_misaligned: got err=%b rdata=%h want 1/0", er, rd); end
        txn(1'b1, 3'b001, 32'h13, 32'h0000FFFF, rd, er, lat);
        n_cmp++; if (er !== 1'b1 || rd !== 32'h0) begin n_mis++; $display("FAIL sh_misaligned: got err=%b rdata=%h want 1/0", er, rd); end
        txn(1'b0, 3'b011, 32'h10, 32'h0, rd, er, lat);
        n_cmp++; if (er !== 1'b1 || rd !== 32'h0) begin n_mis++; $display("FAIL load_f3_011: got err=%b rdata=%h want 1/0", er, rd); end
        txn(1'b1, 3'b100, 32'h10, 32'h01234567, rd, er, lat);
        n_cmp++; if (er !== 1'b1) begin n_mis++; $display("FAIL store_f3_100: got err=%b want 1", er); end
        txn(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat);
        n_cmp++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin n_mis++; $display("FAIL ram_unchanged: got %h err=%b want deadbeef err=0", rd, er); end
    endtask

    task automatic test_byte_store;
        logic [31:0] rd; logic er; int lat;
        txn(1'b1, 3'b000, 32'h11, 32'h12345655, rd, er, lat);
        n_cmp++; if (er !== 1'b0) begin n_mis++; $display("FAIL sb_err: got %b want 0", er); end
        txn(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat);
        n_cmp++; if (rd !== 32'hDEAD55EF) begin n_mis++; $display("FAIL sb_lane1: got %h want dead55ef", rd); end
    endtask

    task automatic test_hold;
        int n;
        req_valid = 1'b1; req_we = 1'b0; funct3 = 3'b010; addr = 32'h10; wdata = 32'h0;
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 10) begin
            @(posedge clk); #1; n++;
        end
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (rsp_valid !== 1'b1) begin n_mis++; $display("FAIL hold_valid[%0d]: got %b want 1", i, rsp_valid); end
            n_cmp++; if (rsp_rdata !== 32'hDEAD55EF || rsp_err !== 1'b0) begin n_mis++; $display("FAIL hold_data[%0d]: got %h err=%b want dead55ef err=0", i, rsp_rdata, rsp_err); end
            n_cmp++; if (req_ready !== 1'b0) begin n_mis++; $display("FAIL hold_req_ready[%0d]: got %b want 0", i, req_ready); end
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_mis++; $display("FAIL hold_release: got valid=%b busy=%b want 0/0", rsp_valid, busy); end
    endtask

    task automatic test_reset_access;
        logic [31:0] rd; logic er; int lat;
        txn(1'b1, 3'b010, 32'h20, 32'h0BADC0DE, rd, er, lat);
        req_valid = 1'b1; req_we = 1'b1; funct3 = 3'b010; addr = 32'h20; wdata = 32'hCAFEF00D;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_mis++; $display("FAIL rst_access_entry: got busy=%b want 1", busy); end
        rst = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0) begin n_mis++; $display("FAIL rst_access_ctrl: got ready=%b busy=%b valid=%b want 1/0/0", req_ready, busy, rsp_valid); end
        n_cmp++; if (rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin n_mis++; $display("FAIL rst_access_data: got %h err=%b want 0/0", rsp_rdata, rsp_err); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        txn(1'b0, 3'b010, 32'h20, 32'h0, rd, er, lat);
        n_cmp++; if (rd !== 32'h0BADC0DE) begin n_mis++; $display("FAIL rst_no_commit: got %h want 0badc0de", rd); end
    endtask

    task automatic test_wrap;
        logic [31:0] rd; logic er; int lat;
        txn(1'b1, 3'b010, 32'h80, 32'h11223344, rd, er, lat);
        txn(1'b0, 3'b010, 32'h00, 32'h0, rd, er, lat);
        n_cmp++; if (rd !== 32'h11223344) begin n_mis++; $display("FAIL wrap_lw_0x00: got %h want 11223344", rd); end
        txn(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat);
        n_cmp++; if (rd !== 32'hDEAD55EF) begin n_mis++; $display("FAIL wrap_neighbour: got %h want dead55ef", rd); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] addrs [4];
        logic [31:0] exps  [4];
        int acc, ret, cyc, first, last, want_span;
        logic acc_now, ret_now;
        addrs[0] = 32'h10; addrs[1] = 32'h00; addrs[2] = 32'h20; addrs[3] = 32'h10;
        exps[0] = 32'hDEAD55EF; exps[1] = 32'h11223344; exps[2] = 32'h0BADC0DE; exps[3] = 32'hDEAD55EF;
`ifdef LSU_BACK2BACK_EN
        want_span = 8;
`else
        want_span = 11;
`endif
        req_valid = 1'b1; req_we = 1'b0; funct3 = 3'b010; addr = addrs[0]; wdata = 32'h0;
        rsp_ready = 1'b1;
        acc = 0; ret = 0; cyc = 0; first = -1; last = -1;
        while (ret < 4 && cyc < 40) begin
            acc_now = req_valid && req_ready;
            ret_now = rsp_valid && rsp_ready;
            if (ret_now) begin
                n_cmp++; if (rsp_rdata !== exps[ret]) begin n_mis++; $display("FAIL b2b_data[%0d]: got %h want %h", ret, rsp_rdata, exps[ret]); end
                ret++;
                last = cyc;
            end
            if (acc_now) begin
                if (first < 0) first = cyc;
                acc++;
            end
            @(posedge clk); #1;
            cyc++;
            if (acc_now) begin
                if (acc < 4) addr = addrs[acc];
                else req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        n_cmp++; if (ret !== 4) begin n_mis++; $display("FAIL b2b_count: got %0d want 4", ret); end
        n_cmp++; if (last - first !== want_span) begin n_mis++; $display("FAIL b2b_cycles: got %0d want %0d", last - first, want_span); end
    endtask

    initial begin
        n_cmp = 0; n_mis = 0;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; funct3 = 3'b000;
        addr = 32'h0; wdata = 32'h0; rsp_ready = 1'b0;
        test_reset;
        test_store_load;
        test_extend;
        test_errors;
        test_byte_store;
        test_hold;
        test_reset_access;
        test_wrap;
        test_back_to_back;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

`default_nettype wire
